verinject_ff_burst_injector: RTL and testbench

Parametrised flip-flop fault injector for one register in the instrumented design. It sits on the register's output path and passes `unmodified` to `modified`, except when an injection is armed. Each injection is triggered by the global `verinject__injector_state` and XORs in a burst of up to `BURST` adjacent flipped bits. The upset can last one cycle, a programmable number of cycles, or until the register is next written.

---
 rtl/verinject_pkg.sv | 19 +
 rtl/verinject_burst_mask_gen.sv | 32 +++
 rtl/verinject_ff_burst_injector.sv | 129 ++++++++++++
 tb/tb_verinject_ff_burst_injector.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/verinject_pkg.sv
// Shared constants for the verinject fault-injection blocks.
// Mode and FSM encodings plus a vector-width helper.
package verinject_pkg;

  localparam int VJ_STATE_W = 32;

  localparam logic [1:0] VJ_MODE_OFF       = 2'd0;
  localparam logic [1:0] VJ_MODE_TRANSIENT = 2'd1;
  localparam logic [1:0] VJ_MODE_HOLD      = 2'd2;
  localparam logic [1:0] VJ_MODE_STICKY    = 2'd3;

  localparam logic [0:0] VJ_ST_IDLE   = 1'b0;
  localparam logic [0:0] VJ_ST_ACTIVE = 1'b1;

  function automatic int vj_width(int l, int r);
    return (l > r) ? (l - r + 1) : (r - l + 1);
  endfunction

endpackage

// File: rtl/verinject_burst_mask_gen.sv
// Burst mask: bits k..k+BURST-1 counted from the LSB end.
// Bits past the MSB are dropped rather than wrapped.
module verinject_burst_mask_gen
  import verinject_pkg::*;
#(
  parameter  int LEFT  = 0,
  parameter  int RIGHT = 0,
  parameter  int BURST = 1,
  localparam int W     = vj_width(LEFT, RIGHT)
) (
  input  logic [VJ_STATE_W-1:0] offset_i,
  input  logic                  in_window_i,
  output logic [W-1:0]          mask_o
);

  logic [VJ_STATE_W:0] lo;
  logic [VJ_STATE_W:0] hi;

  assign lo = {1'b0, offset_i};
  assign hi = lo + (VJ_STATE_W+1)'(BURST);

  always_comb begin
    mask_o = '0;
    for (int i = 0; i < W; i++) begin
      if (in_window_i
          && ((VJ_STATE_W+1)'(i) >= lo)
          && ((VJ_STATE_W+1)'(i) < hi))
        mask_o[i] = 1'b1;
    end
  end

endmodule

// File: rtl/verinject_ff_burst_injector.sv
// Flip-flop fault injector: XORs a burst mask onto one register output
// for one cycle, a held count of cycles, or until the next write.
module verinject_ff_burst_injector
  import verinject_pkg::*;
#(
  parameter  int          LEFT    = 0,
  parameter  int          RIGHT   = 0,
  parameter  int unsigned P_START = 0,
  parameter  int          BURST   = 1,
  parameter  int          HOLD_W  = 8,
  localparam int          W       = vj_width(LEFT, RIGHT)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  do_write,
  input  logic [LEFT:RIGHT]     unmodified,
  output logic [LEFT:RIGHT]     modified,
  input  logic [VJ_STATE_W-1:0] verinject__injector_state,
  input  logic [1:0]            inject_mode,
  input  logic [HOLD_W-1:0]     hold_cycles,
  output logic                  active,
  output logic [15:0]           inject_count
);

  logic [0:0]            fsm_q, fsm_d;
  logic [1:0]            mode_q, mode_d;
  logic [W-1:0]          mask_q, mask_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [VJ_STATE_W-1:0] last_q;
  logic [15:0]           cnt_q, cnt_d;

  logic [VJ_STATE_W:0]   st_x, lo_x, hi_x;
  logic [VJ_STATE_W-1:0] offset;
  logic                  in_win;
  logic                  trigger;
  logic [W-1:0]          mask_new;
  logic [HOLD_W-1:0]     hold_load;

  // 33-bit window so a P_START near the top cannot wrap to zero
  assign st_x   = {1'b0, verinject__injector_state};
  assign lo_x   = (VJ_STATE_W+1)'(P_START);
  assign hi_x   = lo_x + (VJ_STATE_W+1)'(W);
  assign in_win = (st_x >= lo_x) && (st_x < hi_x);
  assign offset = verinject__injector_state - VJ_STATE_W'(P_START);

  verinject_burst_mask_gen #(
    .LEFT  (LEFT),
    .RIGHT (RIGHT),
    .BURST (BURST)
  ) u_mask (
    .offset_i    (offset),
    .in_window_i (in_win),
    .mask_o      (mask_new)
  );

  assign trigger = (inject_mode != VJ_MODE_OFF)
                && in_win
                && (verinject__injector_state != last_q)
                && (fsm_q == VJ_ST_IDLE);

  always_comb begin
    hold_load = HOLD_W'(1);
    if (inject_mode == VJ_MODE_HOLD && hold_cycles != '0)
      hold_load = hold_cycles;
  end

  always_comb begin
    fsm_d  = fsm_q;
    mode_d = mode_q;
    mask_d = mask_q;
    hold_d = hold_q;
    cnt_d  = cnt_q;
    unique case (1'b1)
      (fsm_q == VJ_ST_IDLE): begin
        mask_d = '0;
        if (trigger) begin
          fsm_d  = VJ_ST_ACTIVE;
          mode_d = inject_mode;
          mask_d = mask_new;
          hold_d = hold_load;
          if (cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
        end
      end
      (fsm_q == VJ_ST_ACTIVE): begin
        if (mode_q == VJ_MODE_STICKY) begin
          if (do_write) begin
            fsm_d  = VJ_ST_IDLE;
            mask_d = '0;
          end
        end else begin
          hold_d = hold_q - HOLD_W'(1);
          if (hold_q <= HOLD_W'(1)) begin
            fsm_d  = VJ_ST_IDLE;
            mask_d = '0;
            hold_d = '0;
          end
        end
      end
      default: begin
        fsm_d  = VJ_ST_IDLE;
        mask_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q  <= VJ_ST_IDLE;
      mode_q <= VJ_MODE_OFF;
      mask_q <= '0;
      hold_q <= '0;
      last_q <= '1;
      cnt_q  <= '0;
    end else begin
      fsm_q  <= fsm_d;
      mode_q <= mode_d;
      mask_q <= mask_d;
      hold_q <= hold_d;
      last_q <= verinject__injector_state;
      cnt_q  <= cnt_d;
    end
  end

  assign modified     = unmodified ^ mask_q;
  assign active       = (fsm_q == VJ_ST_ACTIVE);
  assign inject_count = cnt_q;

endmodule

// File: tb/tb_verinject_ff_burst_injector.sv
// Bench for verinject_ff_burst_injector: three instances on shared inputs
// checked against a cycle-level model of the injection rules.
module tb_verinject_ff_burst_injector;

  localparam int N = 3;
  localparam int unsigned PS [N] = '{32'd10, 32'd10, 32'hFFFF_FFFC};
  localparam int          BU [N] = '{1, 3, 2};

  logic        clock = 1'b0;
  logic        reset_n;
  logic        do_write;
  logic [7:0]  unm;
  logic [31:0] state;
  logic [1:0]  mode;
  logic [7:0]  hold;

  logic [N-1:0][7:0]  mod;
  logic [N-1:0]       act;
  logic [N-1:0][15:0] cnt;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]  m_mask [N];
  int          m_rem  [N];
  bit          m_stk  [N];
  logic [15:0] m_cnt  [N];
  logic [31:0] m_last;

  always #5 clock = ~clock;

  verinject_ff_burst_injector #(
    .LEFT(7), .RIGHT(0), .P_START(32'd10), .BURST(1), .HOLD_W(8)
  ) u_a (
    .clock(clock), .reset_n(reset_n), .do_write(do_write),
    .unmodified(unm), .modified(mod[0]),
    .verinject__injector_state(state), .inject_mode(mode),
    .hold_cycles(hold), .active(act[0]), .inject_count(cnt[0])
  );

  verinject_ff_burst_injector #(
    .LEFT(7), .RIGHT(0), .P_START(32'd10), .BURST(3), .HOLD_W(8)
  ) u_b (
    .clock(clock), .reset_n(reset_n), .do_write(do_write),
    .unmodified(unm), .modified(mod[1]),
    .verinject__injector_state(state), .inject_mode(mode),
    .hold_cycles(hold), .active(act[1]), .inject_count(cnt[1])
  );

  verinject_ff_burst_injector #(
    .LEFT(7), .RIGHT(0), .P_START(32'hFFFF_FFFC), .BURST(2), .HOLD_W(8)
  ) u_c (
    .clock(clock), .reset_n(reset_n), .do_write(do_write),
    .unmodified(unm), .modified(mod[2]),
    .verinject__injector_state(state), .inject_mode(mode),
    .hold_cycles(hold), .active(act[2]), .inject_count(cnt[2])
  );

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_mask[i] = '0;
      m_rem[i]  = 0;
      m_stk[i]  = 1'b0;
      m_cnt[i]  = '0;
    end
    m_last = 32'hFFFF_FFFF;
  endtask

  task automatic check_all(string tag);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s.mod%0d", tag, i), 32'(mod[i]), 32'(unm ^ m_mask[i]));
      check($sformatf("%s.act%0d", tag, i), 32'(act[i]), 32'(m_mask[i] != 0));
      check($sformatf("%s.cnt%0d", tag, i), 32'(cnt[i]), 32'(m_cnt[i]));
    end
  endtask

  function automatic bit owns(int i, logic [31:0] s);
    logic [63:0] s64, p64;
    s64 = 64'(s);
    p64 = 64'(PS[i]);
    return (s64 >= p64) && (s64 < p64 + 64'd8);
  endfunction

  // What the rules say happens at the coming rising edge
  task automatic model_edge();
    int full;
    int k;
    for (int i = 0; i < N; i++) begin
      if (m_mask[i] != 0) begin
        if (m_stk[i]) begin
          if (do_write) m_mask[i] = '0;
        end else begin
          m_rem[i] = m_rem[i] - 1;
          if (m_rem[i] == 0) m_mask[i] = '0;
        end
      end else if (mode != 2'd0 && owns(i, state) && state != m_last) begin
        k         = int'(state - PS[i]);
        full      = ((1 << BU[i]) - 1) << k;
        m_mask[i] = full[7:0];
        m_stk[i]  = (mode == 2'd3);
        m_rem[i]  = (mode == 2'd2) ? ((hold == 0) ? 1 : int'(hold)) : 1;
        if (m_cnt[i] != 16'hFFFF) m_cnt[i] = m_cnt[i] + 16'd1;
      end
    end
    m_last = state;
  endtask

  task automatic step(string tag);
    @(negedge clock);
    check_all(tag);
    if (reset_n) model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic steps(string tag, int n);
    for (int j = 0; j < n; j++) step(tag);
  endtask

  initial begin
    int r;
    reset_n  = 1'b0;
    do_write = 1'b0;
    unm      = 8'h5A;
    state    = 32'd0;
    mode     = 2'd0;
    hold     = 8'd0;
    model_reset();
    #1;
    check_all("rst0");
    steps("rst", 2);
    reset_n = 1'b1;
    steps("idle", 2);

    // transient, single bit at offset 0
    unm   = 8'h00;
    mode  = 2'd1;
    state = 32'd10;
    step("tr_trig");
    state = 32'd0;
    check("tr_a_bit0", 32'(mod[0]), 32'h01);
    check("tr_a_cnt", 32'(cnt[0]), 32'd1);
    steps("tr", 3);

    // hold for 4 cycles at k=6, burst truncated at the MSB
    mode  = 2'd2;
    hold  = 8'd4;
    state = 32'd16;
    step("hd_trig");
    state = 32'd0;
    check("hd_b_trunc", 32'(mod[1]), 32'hC0);
    check("hd_a_bit6", 32'(mod[0]), 32'h40);
    steps("hd", 6);

    // sticky at k=3; write in the trigger cycle and a mode change are ignored
    unm      = 8'hFF;
    mode     = 2'd3;
    state    = 32'd13;
    do_write = 1'b1;
    step("st_trig");
    do_write = 1'b0;
    mode     = 2'd1;
    check("st_a_bit3", 32'(mod[0]), 32'hF7);
    steps("st_hold", 19);
    do_write = 1'b1;
    step("st_wr");
    do_write = 1'b0;
    steps("st_after", 3);

    // constant state triggers only once
    unm   = 8'h3C;
    mode  = 2'd1;
    state = 32'd10;
    steps("held", 50);

    // stepping state while active is ignored
    state = 32'd0;
    step("gap");
    mode  = 2'd2;
    hold  = 8'd5;
    state = 32'd10;
    step("rt_trig");
    state = 32'd11;
    steps("rt_step", 6);

    // window edges and the no-wrap case near the top of the state space
    state = 32'd9;
    step("oow9");
    state = 32'd18;
    step("oow18");
    state = 32'd5;
    step("oow5");
    state = 32'd0;
    steps("nowrap0", 3);
    state = 32'hFFFF_FFFF;
    hold  = 8'd0;
    steps("top", 3);

    // asynchronous reset in the middle of a hold injection
    state = 32'd0;
    step("pre_rst");
    mode  = 2'd2;
    hold  = 8'd6;
    state = 32'd12;
    steps("mr_trig", 3);
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("mr_async");
    steps("mr_hold", 2);
    reset_n = 1'b1;
    state   = 32'd0;
    step("mr_rel");
    state = 32'd12;
    steps("mr_again", 4);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)      state = 32'($urandom_range(8, 19));
      else if (r < 9) state = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
      else            state = 32'($urandom_range(0, 3));
      mode     = 2'($urandom_range(0, 3));
      hold     = 8'($urandom_range(0, 6));
      do_write = ($urandom_range(0, 5) == 0);
      unm      = 8'($urandom);
      step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
